// File: rtl/inbuf_pkg.sv
// Shared types and constants for the ping/pong input feature buffer.
// Bank ownership encoding, lane/row address split helpers, error-counter width.
package inbuf_pkg;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    // Low address bits select the lane, the rest select the row.
    function automatic int lane_bits(input int lanes);
        return $clog2(lanes);
    endfunction

    function automatic int row_bits(input int addr_w, input int lanes);
        return addr_w - $clog2(lanes);
    endfunction

endpackage

// File: rtl/inbuf_bank.sv
// One buffer bank: LANES sub-RAMs written one word at a time, read one
// LANES-wide row per access with one cycle of latency. Contents are not reset.
module inbuf_bank
    import inbuf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BANK_DEPTH = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int LANES      = 4
) (
    input  logic                                             clk,
    input  logic                                             wr_en,
    input  logic [ADDR_WIDTH-1:0]                            wr_addr,
    input  logic [DATA_WIDTH-1:0]                            wr_data,
    input  logic                                             rd_en,
    input  logic [row_bits(ADDR_WIDTH, LANES)-1:0]           rd_row,
    output logic [LANES*DATA_WIDTH-1:0]                      rd_data
);

    localparam int LANE_BITS = lane_bits(LANES);
    localparam int ROW_W     = row_bits(ADDR_WIDTH, LANES);
    localparam int ROWS      = BANK_DEPTH / LANES;

    logic [LANE_BITS-1:0] wr_lane;
    logic [ROW_W-1:0]     wr_row;

    assign wr_lane = wr_addr[LANE_BITS-1:0];
    assign wr_row  = wr_addr[ADDR_WIDTH-1:LANE_BITS];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem [ROWS];
        logic [DATA_WIDTH-1:0] rd_word_d;
        logic [DATA_WIDTH-1:0] rd_word_q;

        always_ff @(posedge clk) begin
            if (wr_en && (wr_lane == LANE_BITS'(k))) begin
                mem[wr_row] <= wr_data;
            end
        end

        always_comb begin
            rd_word_d = rd_word_q;
            if (rd_en) begin
                rd_word_d = mem[rd_row];
            end
        end

        always_ff @(posedge clk) begin
            rd_word_q <= rd_word_d;
        end

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_word_q;
    end

endmodule

// File: rtl/input_buffer_pingpong.sv
// Ping/pong input buffer: writer fills one bank while the reader drains the other.
// Optional saturating violation counter built only when INBUF_ERR_CNT_EN is defined.
module input_buffer_pingpong
    import inbuf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BANK_DEPTH = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int ROW_WIDTH  = ADDR_WIDTH - $clog2(LANES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_commit,
    output logic                          wr_ready,
    output logic                          wr_bank,
    input  logic                          rd_en,
    input  logic [ROW_WIDTH-1:0]          rd_row,
    output logic [LANES*DATA_WIDTH-1:0]   rd_data,
    output logic                          rd_valid,
    output logic                          rd_avail,
    input  logic                          rd_release,
    output logic                          rd_bank,
    output logic                          err_sticky,
    output logic [ERR_CNT_W-1:0]          err_cnt
);

    // Handshake rules: a write/commit is accepted only while the write bank is
    // EMPTY (wr_ready); a read/release only while the read bank is FULL
    // (rd_avail). Anything presented outside those windows is dropped and
    // counted as a protocol violation.

    bank_state_e state_d [2];
    bank_state_e state_q [2];
    logic        wr_sel_d, wr_sel_q;
    logic        rd_sel_d, rd_sel_q;
    logic        rd_valid_d, rd_valid_q;
    logic        rd_src_d, rd_src_q;
    logic        err_sticky_d, err_sticky_q;
    logic [LANES*DATA_WIDTH-1:0] rd_hold_d, rd_hold_q;
    logic [LANES*DATA_WIDTH-1:0] bank_rd [2];

    logic wr_fire, commit_fire, rd_fire, rel_fire, err_any;

    assign wr_ready = (state_q[wr_sel_q] == BANK_EMPTY);
    assign rd_avail = (state_q[rd_sel_q] == BANK_FULL);
    assign wr_bank  = wr_sel_q;
    assign rd_bank  = rd_sel_q;

    assign wr_fire     = wr_en      && wr_ready;
    assign commit_fire = wr_commit  && wr_ready;
    assign rd_fire     = rd_en      && rd_avail;
    assign rel_fire    = rd_release && rd_avail;

    assign err_any = (wr_en      && !wr_ready) || (wr_commit  && !wr_ready) ||
                     (rd_en      && !rd_avail) || (rd_release && !rd_avail);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        inbuf_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .BANK_DEPTH (BANK_DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .LANES      (LANES)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_fire && (wr_sel_q == 1'(b))),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_en   (rd_fire && (rd_sel_q == 1'(b))),
            .rd_row  (rd_row),
            .rd_data (bank_rd[b])
        );
    end

    // The bank read registers hold their last row, but the visible output must
    // hold whatever was last presented, so it is captured here every cycle.
    assign rd_data  = rd_valid_q ? bank_rd[rd_src_q] : rd_hold_q;
    assign rd_valid = rd_valid_q;

    // Commit and release can never target the same bank: the write bank is
    // EMPTY whenever a commit fires, the read bank FULL whenever a release fires.
    always_comb begin
        state_d[0]   = state_q[0];
        state_d[1]   = state_q[1];
        wr_sel_d     = wr_sel_q;
        rd_sel_d     = rd_sel_q;
        rd_valid_d   = rd_fire;
        rd_src_d     = rd_fire ? rd_sel_q : rd_src_q;
        rd_hold_d    = rd_data;
        err_sticky_d = err_sticky_q || err_any;

        if (commit_fire) begin
            state_d[wr_sel_q] = BANK_FULL;
            wr_sel_d          = !wr_sel_q;
        end
        if (rel_fire) begin
            state_d[rd_sel_q] = BANK_EMPTY;
            rd_sel_d          = !rd_sel_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0]   <= BANK_EMPTY;
            state_q[1]   <= BANK_EMPTY;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_src_q     <= 1'b0;
            rd_hold_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q[0]   <= state_d[0];
            state_q[1]   <= state_d[1];
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            rd_valid_q   <= rd_valid_d;
            rd_src_q     <= rd_src_d;
            rd_hold_q    <= rd_hold_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky = err_sticky_q;

`ifdef INBUF_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_any && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_input_buffer_pingpong.sv
// Self-checking bench for input_buffer_pingpong: directed scenarios plus
// randomized traffic checked against a bank-level behavioural model.
module tb_input_buffer_pingpong;

    localparam int DW    = 16;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int L     = 4;
    localparam int RW    = 6;
`ifdef INBUF_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic            wr_commit = 1'b0;
    logic            wr_ready;
    logic            wr_bank;
    logic            rd_en = 1'b0;
    logic [RW-1:0]   rd_row = '0;
    logic [L*DW-1:0] rd_data;
    logic            rd_valid;
    logic            rd_avail;
    logic            rd_release = 1'b0;
    logic            rd_bank;
    logic            err_sticky;
    logic [7:0]      err_cnt;

    int checks = 0;
    int failures = 0;

    // Behavioural model: two word arrays, a full flag per bank, two pointers.
    logic [DW-1:0]   m_mem [2][DEPTH];
    bit              m_full [2];
    bit              m_wsel, m_rsel;
    bit              m_valid;
    logic [L*DW-1:0] m_data;
    bit              m_sticky;
    int              m_cnt;

    input_buffer_pingpong dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_commit  (wr_commit),
        .wr_ready   (wr_ready),
        .wr_bank    (wr_bank),
        .rd_en      (rd_en),
        .rd_row     (rd_row),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_avail   (rd_avail),
        .rd_release (rd_release),
        .rd_bank    (rd_bank),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_cnt();
        return CNT_EN ? 8'(m_cnt) : 8'd0;
    endfunction

    task automatic model_reset();
        m_full[0] = 0; m_full[1] = 0;
        m_wsel = 0; m_rsel = 0;
        m_valid = 0; m_data = '0;
        m_sticky = 0; m_cnt = 0;
    endtask

    // Advance model by the current inputs, clock once, release all strobes.
    task automatic step();
        bit ready, avail, err;
        ready = !m_full[m_wsel];
        avail = m_full[m_rsel];
        err = (wr_en && !ready) || (wr_commit && !ready) ||
              (rd_en && !avail) || (rd_release && !avail);
        m_valid = rd_en && avail;
        if (m_valid) begin
            for (int k = 0; k < L; k++) m_data[k*DW +: DW] = m_mem[m_rsel][int'(rd_row)*L + k];
        end
        if (wr_en && ready) m_mem[m_wsel][wr_addr] = wr_data;
        if (wr_commit && ready) begin m_full[m_wsel] = 1; m_wsel = !m_wsel; end
        if (rd_release && avail) begin m_full[m_rsel] = 0; m_rsel = !m_rsel; end
        if (err) begin m_sticky = 1; if (m_cnt < 255) m_cnt++; end
        @(posedge clk);
        #1;
        wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%0b exp=1", wr_ready); end
        checks++; if (rd_avail !== 1'b0) begin failures++; $display("FAIL reset_rd_avail got=%0b exp=0", rd_avail); end
        checks++; if ({wr_bank, rd_bank} !== 2'b00) begin failures++; $display("FAIL reset_banks got=%0b%0b exp=00", wr_bank, rd_bank); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== '0) begin failures++; $display("FAIL reset_rd got valid=%0b data=%h exp 0/0", rd_valid, rd_data); end
        checks++; if (err_sticky !== 1'b0 || err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err got sticky=%0b cnt=%0d exp 0/0", err_sticky, err_cnt); end
    endtask

    task automatic test_fill_commit();
        for (int a = 0; a < DEPTH; a++) begin
            wr_en = 1; wr_addr = AW'(a); wr_data = DW'(a * 3);
            wr_commit = (a == DEPTH - 1);
            step();
        end
        checks++; if (wr_bank !== 1'b1) begin failures++; $display("FAIL commit_wr_bank got=%0b exp=1", wr_bank); end
        checks++; if (rd_avail !== 1'b1 || rd_bank !== 1'b0) begin failures++; $display("FAIL commit_rd got avail=%0b bank=%0b exp 1/0", rd_avail, rd_bank); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL commit_wr_ready got=%0b exp=1", wr_ready); end
    endtask

    task automatic test_read_row();
        logic [L*DW-1:0] exp, held;
        exp = {16'd33, 16'd30, 16'd27, 16'd24};
        rd_en = 1; rd_row = 6'd2;
        step();
        checks++; if (rd_valid !== 1'b1 || rd_data !== exp) begin failures++; $display("FAIL read_row2 got valid=%0b data=%h exp 1/%h", rd_valid, rd_data, exp); end
        held = rd_data;
        step();
        checks++; if (rd_valid !== 1'b0 || rd_data !== held) begin failures++; $display("FAIL read_hold got valid=%0b data=%h exp 0/%h", rd_valid, rd_data, held); end
    endtask

    task automatic test_fill_while_read();
        for (int a = 0; a < DEPTH; a++) begin
            wr_en = 1; wr_addr = AW'(a); wr_data = DW'($urandom);
            wr_commit = (a == DEPTH - 1);
            rd_en = $urandom_range(0, 1); rd_row = RW'($urandom);
            step();
            checks++; if (rd_valid !== m_valid || rd_data !== m_data) begin failures++; $display("FAIL overlap_read a=%0d got %0b/%h exp %0b/%h", a, rd_valid, rd_data, m_valid, m_data); end
        end
        checks++; if (wr_ready !== 1'b0 || rd_avail !== 1'b1) begin failures++; $display("FAIL both_full got ready=%0b avail=%0b exp 0/1", wr_ready, rd_avail); end
    endtask

    task automatic test_dropped_write();
        wr_en = 1; wr_addr = 8'd5; wr_data = 16'hBEEF;
        step();
        checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL drop_sticky got=%0b exp=1", err_sticky); end
        checks++; if (err_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin failures++; $display("FAIL drop_cnt got=%0d exp=%0d", err_cnt, CNT_EN ? 1 : 0); end
        rd_en = 1; rd_row = 6'd1;
        step();
        checks++; if (rd_data[1*DW +: DW] !== 16'd15) begin failures++; $display("FAIL drop_readback got=%h exp=000f", rd_data[1*DW +: DW]); end
    endtask

    task automatic test_release();
        logic [L*DW-1:0] exp;
        exp = {16'd45, 16'd42, 16'd39, 16'd36};
        rd_en = 1; rd_row = 6'd3; rd_release = 1;
        step();
        checks++; if (rd_valid !== 1'b1 || rd_data !== exp) begin failures++; $display("FAIL release_read got %0b/%h exp 1/%h", rd_valid, rd_data, exp); end
        checks++; if (rd_bank !== 1'b1 || rd_avail !== 1'b1) begin failures++; $display("FAIL release_rd got bank=%0b avail=%0b exp 1/1", rd_bank, rd_avail); end
        checks++; if (wr_ready !== 1'b1 || wr_bank !== 1'b0) begin failures++; $display("FAIL release_wr got ready=%0b bank=%0b exp 1/0", wr_ready, wr_bank); end
        for (int r = 0; r < 8; r++) begin
            rd_en = 1; rd_row = RW'($urandom);
            step();
            checks++; if (rd_data !== m_data) begin failures++; $display("FAIL bank1_read got %h exp %h", rd_data, m_data); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            wr_en = $urandom_range(0, 1); wr_addr = AW'($urandom); wr_data = DW'($urandom);
            wr_commit = ($urandom_range(0, 15) == 0);
            rd_en = $urandom_range(0, 1); rd_row = RW'($urandom);
            rd_release = ($urandom_range(0, 15) == 0);
            step();
            checks++;
            if (rd_valid !== m_valid || rd_data !== m_data || wr_ready !== !m_full[m_wsel] ||
                rd_avail !== m_full[m_rsel] || wr_bank !== m_wsel || rd_bank !== m_rsel ||
                err_sticky !== m_sticky || err_cnt !== exp_cnt()) begin
                failures++;
                $display("FAIL random c=%0d got v=%0b d=%h wr=%0b ra=%0b wb=%0b rb=%0b es=%0b ec=%0d exp v=%0b d=%h wr=%0b ra=%0b wb=%0b rb=%0b es=%0b ec=%0d",
                         c, rd_valid, rd_data, wr_ready, rd_avail, wr_bank, rd_bank, err_sticky, err_cnt,
                         m_valid, m_data, !m_full[m_wsel], m_full[m_rsel], m_wsel, m_rsel, m_sticky, exp_cnt());
            end
        end
    endtask

    task automatic test_err_saturate();
        apply_reset();
        rd_release = 1;
        step();
        checks++; if (rd_bank !== 1'b0 || err_sticky !== 1'b1) begin failures++; $display("FAIL bad_release got bank=%0b sticky=%0b exp 0/1", rd_bank, err_sticky); end
        for (int i = 0; i < 300; i++) begin
            rd_en = 1; rd_row = RW'($urandom);
            step();
            checks++; if (rd_valid !== 1'b0 || rd_data !== '0) begin failures++; $display("FAIL empty_read i=%0d got %0b/%h exp 0/0", i, rd_valid, rd_data); end
        end
        checks++; if (err_cnt !== (CNT_EN ? 8'd255 : 8'd0)) begin failures++; $display("FAIL err_saturate got=%0d exp=%0d", err_cnt, CNT_EN ? 255 : 0); end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                wr_en = 1; wr_addr = AW'(a); wr_data = DW'($urandom);
                wr_commit = (a == DEPTH - 1);
                step();
            end
        end
        rd_en = 1; rd_row = RW'($urandom);
        step();
        checks++; if (rd_valid !== 1'b1 || rd_data !== m_data) begin failures++; $display("FAIL pre_reset_read got %0b/%h exp 1/%h", rd_valid, rd_data, m_data); end
        rst_n = 0;
        #1;
        checks++; if (rd_valid !== 1'b0 || rd_data !== '0) begin failures++; $display("FAIL midreset_rd got %0b/%h exp 0/0", rd_valid, rd_data); end
        checks++; if (wr_ready !== 1'b1 || rd_avail !== 1'b0) begin failures++; $display("FAIL midreset_state got ready=%0b avail=%0b exp 1/0", wr_ready, rd_avail); end
        checks++; if ({wr_bank, rd_bank} !== 2'b00) begin failures++; $display("FAIL midreset_ptrs got=%0b%0b exp=00", wr_bank, rd_bank); end
        apply_reset();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill_commit();
        test_read_row();
        test_fill_while_read();
        test_dropped_write();
        test_release();
        test_random();
        test_err_saturate();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
